hazard_scoreboard: RTL

- Tracks destination registers of in-flight instructions in the E, M and W stages of the pipelined CPU.
- Tells the D stage, for each source operand, whether to stall or which stage to forward from.
- Sits between the decoder and the register file, and drives the RF write-back address/enable from its W entry.
- Each source is resolved with the Tuse/Tnew rule.

---
 rtl/hazard_scoreboard.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Tracks the destination registers of in-flight instructions in the E, M and
// W stages and resolves each D-stage source operand with the Tuse/Tnew rule:
// stall when the youngest producer is not ready in time, otherwise pick the
// forwarding stage or the register file. The W entry also drives the register
// file write port.
//
// Optional build macro RF_BYPASS_EN: the register file is write-through
// bypassed, so a ready W-stage producer is read from the RF (code 0) instead
// of being forwarded from W (code 3).
//
// Handshake: D is offered when d_valid = 1. It is accepted on the rising edge
// when d_valid && !stall. While stall = 1 the upstream holds the D inputs
// stable. M and W advance every cycle regardless of stall.

module hazard_scoreboard (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_valid,
  input  logic [4:0]  d_rs_addr,
  input  logic        d_rs_ren,
  input  logic [1:0]  d_rs_tuse,
  input  logic [4:0]  d_rt_addr,
  input  logic        d_rt_ren,
  input  logic [1:0]  d_rt_tuse,
  input  logic [4:0]  d_wr_addr,
  input  logic        d_wr_en,
  input  logic [1:0]  d_tnew,
  output logic        stall,
  output logic [1:0]  fwd_rs_sel,
  output logic [1:0]  fwd_rt_sel,
  output logic [4:0]  wb_addr,
  output logic        wb_en,
  output logic [31:0] busy_mask
);

  typedef struct packed {
    logic       valid;
    logic [4:0] addr;
    logic       wen;
    logic [1:0] tnew;
  } entry_t;

  localparam logic [1:0] SEL_RF = 2'd0;
  localparam logic [1:0] SEL_E  = 2'd1;
  localparam logic [1:0] SEL_M  = 2'd2;
`ifdef RF_BYPASS_EN
  // A write-through RF already shows the W value on its read port.
  localparam logic [1:0] SEL_W  = 2'd0;
`else
  localparam logic [1:0] SEL_W  = 2'd3;
`endif

  entry_t r_e;
  entry_t r_m;
  entry_t r_w;

  logic [2:0] w_rs_res;
  logic [2:0] w_rt_res;
  logic       w_rs_act;
  logic       w_rt_act;

  // Move an entry one stage down; its remaining latency shrinks by one.
  function automatic entry_t advance(input entry_t x);
    entry_t y;
    y = x;
    y.tnew = (x.tnew == 2'd0) ? 2'd0 : x.tnew - 2'd1;
    return y;
  endfunction

  // Returns {stall, sel} for one source using the youngest matching entry.
  function automatic logic [2:0] resolve(input logic [4:0] s,
                                         input logic [1:0] tuse,
                                         input entry_t e,
                                         input entry_t m,
                                         input entry_t w);
    logic       hit;
    logic [1:0] tn;
    logic [1:0] code;
    hit  = 1'b1;
    tn   = 2'd0;
    code = SEL_RF;
    if (s == 5'd0) begin
      hit = 1'b0;
    end else if (e.valid && e.wen && e.addr == s) begin
      tn   = e.tnew;
      code = SEL_E;
    end else if (m.valid && m.wen && m.addr == s) begin
      tn   = m.tnew;
      code = SEL_M;
    end else if (w.valid && w.wen && w.addr == s) begin
      tn   = w.tnew;
      code = SEL_W;
    end else begin
      hit = 1'b0;
    end
    if (!hit) return {1'b0, SEL_RF};
    if (tn > tuse) return {1'b1, SEL_RF};
    // Ready now: forward from its stage. Not yet ready but in time: a later
    // stage's forwarder will pick it up, so D reads the RF path for now.
    if (tn == 2'd0) return {1'b0, code};
    return {1'b0, SEL_RF};
  endfunction

  // One-hot of the register an entry will produce but has not produced yet.
  function automatic logic [31:0] busy_of(input entry_t x);
    logic [31:0] v;
    v = '0;
    if (x.valid && x.wen && x.tnew != 2'd0 && x.addr != 5'd0) v[x.addr] = 1'b1;
    return v;
  endfunction

  assign w_rs_res = resolve(d_rs_addr, d_rs_tuse, r_e, r_m, r_w);
  assign w_rt_res = resolve(d_rt_addr, d_rt_tuse, r_e, r_m, r_w);
  assign w_rs_act = d_valid && d_rs_ren;
  assign w_rt_act = d_valid && d_rt_ren;

  assign stall      = (w_rs_act && w_rs_res[2]) || (w_rt_act && w_rt_res[2]);
  assign fwd_rs_sel = w_rs_act ? w_rs_res[1:0] : SEL_RF;
  assign fwd_rt_sel = w_rt_act ? w_rt_res[1:0] : SEL_RF;
  assign busy_mask  = busy_of(r_e) | busy_of(r_m) | busy_of(r_w);

  // Write port comes straight from the W register; no input reaches it.
  assign wb_en   = r_w.valid && r_w.wen && (r_w.addr != 5'd0);
  assign wb_addr = r_w.valid ? r_w.addr : 5'd0;

  // Pipeline advance: W<-M, M<-E always; E<-D on accept, else a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else begin
      r_w <= advance(r_m);
      r_m <= advance(r_e);
      if (d_valid && !stall) begin
        r_e <= '{valid: 1'b1, addr: d_wr_addr, wen: d_wr_en, tnew: d_tnew};
      end else begin
        r_e <= '0;
      end
    end
  end

endmodule
